instruction_fetch: RTL

Instruction fetch stage: holds the program counter, issues word reads to the instruction memory, and buffers the returned 32-bit instructions in a 2-entry queue that feeds the instruction decoder through a valid/ready handshake. It sits directly upstream of the decoder, which slices `out_instr` into rs1/rs2/rd/opcode/immediate fields. Branch and jump redirects from the execute stage flush the queue and restart fetch at the target.

---
 rtl/instruction_fetch.sv | 86 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, word reads to instruction memory,
// and a 2-entry {pc, instr} queue feeding the decoder over valid/ready.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        pop;
  logic        push;
  logic [2:0]  occupancy;

  // Requests are throttled so that every response is guaranteed a free slot.
  always_comb begin
    out_valid = (count != 2'd0) && !redirect_valid;
    pop       = out_valid && out_ready;
    push      = inflight && !redirect_valid;
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    imem_req  = !redirect_valid && (occupancy < 3'd2);
    imem_addr = fetch_pc;
    out_instr = NOP_INSTR;
    out_pc    = 32'h0000_0000;
    if (out_valid) begin
      out_instr = q_instr[rd_ptr];
      out_pc    = q_pc[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= 32'h0000_0000;
      inflight    <= 1'b0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage is pure datapath; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= inflight_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule
